// File: rtl/calc_responder_if.sv
// Request/response bus of calc_responder. Signal names and big-endian
// bit numbering ([0] is the MSB) follow the block's external pin list.
interface calc_responder_if;
  logic [0:3]  req_cmd_in;
  logic [0:1]  req_tag_in;
  logic [0:31] req_data_in;
  logic [0:31] out_data;
  logic [0:1]  out_resp;
  logic [0:1]  out_tag;

  modport master (
    output req_cmd_in, req_tag_in, req_data_in,
    input  out_data, out_resp, out_tag
  );

  modport slave (
    input  req_cmd_in, req_tag_in, req_data_in,
    output out_data, out_resp, out_tag
  );
endinterface

// File: rtl/calc_responder.sv
// Two-cycle command intake, 3-stage add/sub and 1-stage shift/invalid execute, 4-entry response FIFO.
// Optional macro CALC_SHIFT_EN enables the shifter; without it commands 5/6 report invalid.
module calc_responder (
  input  logic             clk,
  input  logic             reset,
  calc_responder_if.slave  bus
);
  localparam int DATA_W = 32;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC_SHIFT_EN
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
`endif
  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_OVF = 2'd2;
  localparam logic [1:0] RESP_INV = 2'd3;

  typedef enum logic {IDLE, OP2} state_t;

  typedef struct packed {
    logic [1:0]        resp;
    logic [1:0]        tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Bit DATA_W is carry-out for add and borrow for sub; both mean out of range.
  function automatic rsp_t fmt_arith(input logic [DATA_W:0] res, input logic [1:0] tag);
    rsp_t r;
    r.tag = tag;
    if (res[DATA_W]) begin
      r.resp = RESP_OVF;
      r.data = '0;
    end else begin
      r.resp = RESP_OK;
      r.data = res[DATA_W-1:0];
    end
    return r;
  endfunction

  logic [3:0]        cmd_in;
  logic [1:0]        tag_in;
  logic [DATA_W-1:0] data_in;
  assign cmd_in  = bus.req_cmd_in;
  assign tag_in  = bus.req_tag_in;
  assign data_in = bus.req_data_in;

  state_t            state_q;
  logic [3:0]        cmd_q;
  logic [1:0]        tag_q;
  logic [DATA_W-1:0] op1_q;

  logic              vld_p0;
  logic [3:0]        cmd_p0;
  logic [1:0]        tag_p0;
  logic [DATA_W-1:0] op1_p0, op2_p0;
  logic              vld_p1;
  logic [1:0]        tag_p1;
  logic [DATA_W:0]   res_p1;
  logic              vld_p2;
  rsp_t              rsp_p2;

  rsp_t              fifo_q [4];
  logic [1:0]        wp_q, rp_q;
  logic [2:0]        cnt_q;
  rsp_t              out_q;

  logic              arith_p0, short_vld;
  rsp_t              short_rsp;
  logic              pop;
  logic [1:0]        n_push, wp_d, rp_d, wp2;
  logic [2:0]        cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      case (state_q)
        IDLE: if (cmd_in != 4'd0) state_q <= OP2;
        OP2: begin
          state_q <= IDLE;
          vld_p0  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      cmd_q <= cmd_in;
      tag_q <= tag_in;
      op1_q <= data_in;
    end
    if (state_q == OP2) begin
      cmd_p0 <= cmd_q;
      tag_p0 <= tag_q;
      op1_p0 <= op1_q;
      op2_p0 <= data_in;
    end
  end

  assign arith_p0  = vld_p0 && (cmd_p0 == CMD_ADD || cmd_p0 == CMD_SUB);
  assign short_vld = vld_p0 && !arith_p0;

  always_comb begin
    short_rsp.resp = RESP_INV;
    short_rsp.tag  = tag_p0;
    short_rsp.data = '0;
`ifdef CALC_SHIFT_EN
    if (cmd_p0 == CMD_SHL) begin
      short_rsp.resp = RESP_OK;
      short_rsp.data = op1_p0 << op2_p0[4:0];
    end else if (cmd_p0 == CMD_SHR) begin
      short_rsp.resp = RESP_OK;
      short_rsp.data = op1_p0 >> op2_p0[4:0];
    end
`endif
  end

  // p0 -> p1: raw 33-bit arithmetic; p1 -> p2: response formatting
  always_ff @(posedge clk) begin
    tag_p1 <= tag_p0;
    res_p1 <= (cmd_p0 == CMD_SUB) ? ({1'b0, op1_p0} - {1'b0, op2_p0})
                                  : ({1'b0, op1_p0} + {1'b0, op2_p0});
    rsp_p2 <= fmt_arith(res_p1, tag_p1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= arith_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Long-path result takes the lower slot when both paths complete together.
  always_comb begin
    pop    = (cnt_q != 3'd0);
    n_push = {1'b0, vld_p2} + {1'b0, short_vld};
    wp_d   = wp_q + n_push;
    rp_d   = rp_q + {1'b0, pop};
    cnt_d  = cnt_q + {1'b0, n_push} - {2'b0, pop};
    wp2    = vld_p2 ? wp_q + 2'd1 : wp_q;
  end

  always_ff @(posedge clk) begin
    if (vld_p2)    fifo_q[wp_q] <= rsp_p2;
    if (short_vld) fifo_q[wp2]  <= short_rsp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      out_q <= pop ? fifo_q[rp_q] : '0;
    end
  end

  assign bus.out_resp = out_q.resp;
  assign bus.out_tag  = out_q.tag;
  assign bus.out_data = out_q.data;
endmodule

// File: tb/tb_calc_responder.sv
// Directed + random bench for calc_responder with a completion-ordered scoreboard.
module tb_calc_responder;
  logic clk;
  logic reset;
  calc_responder_if bus ();

  calc_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         comp;
    int         key;
    logic [1:0] resp;
    logic [1:0] tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_out = -100;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, expv, cyc);
  endtask

  function automatic exp_t model(input logic [3:0] cmd, input logic [1:0] tag,
                                 input logic [31:0] a, input logic [31:0] b, input int t);
    exp_t e;
    logic [32:0] s;
    e.tag  = tag;
    e.resp = 2'd3;
    e.data = 32'h0;
    e.comp = t + 1;
    s = {1'b0, a} + {1'b0, b};
    case (cmd)
      4'd1: begin
        e.comp = t + 3;
        if (s > 33'h0_FFFF_FFFF) e.resp = 2'd2;
        else begin e.resp = 2'd1; e.data = s[31:0]; end
      end
      4'd2: begin
        e.comp = t + 3;
        if (b > a) e.resp = 2'd2;
        else begin e.resp = 2'd1; e.data = a - b; end
      end
`ifdef CALC_SHIFT_EN
      4'd5: begin e.resp = 2'd1; e.data = a << b[4:0]; end
      4'd6: begin e.resp = 2'd1; e.data = a >> b[4:0]; end
`endif
      default: ;
    endcase
    e.key = e.comp * 2 + ((cmd == 4'd1 || cmd == 4'd2) ? 0 : 1);
    return e;
  endfunction

  task automatic sb_insert(input exp_t e);
    int i;
    i = 0;
    while (i < sb.size() && sb[i].key <= e.key) i++;
    sb.insert(i, e);
  endtask

  // Two-cycle request; 'junk' is driven on cmd/tag during the OP2 cycle and must be ignored.
  task automatic issue(input logic [3:0] cmd, input logic [1:0] tag,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] junk);
    bus.req_cmd_in  = cmd;
    bus.req_tag_in  = tag;
    bus.req_data_in = a;
    @(posedge clk); #1;
    bus.req_cmd_in  = junk;
    bus.req_tag_in  = ~tag;
    bus.req_data_in = b;
    sb_insert(model(cmd, tag, a, b, cyc));
    @(posedge clk); #1;
    bus.req_cmd_in  = 4'd0;
    bus.req_tag_in  = 2'd0;
    bus.req_data_in = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every cycle: the head of the scoreboard is due at max(completion+2, previous output+1).
  always @(negedge clk) begin
    int   due;
    logic hit;
    hit = 1'b0;
    if (sb.size() > 0) begin
      due = (sb[0].comp + 2 > last_out + 1) ? sb[0].comp + 2 : last_out + 1;
      hit = (due == cyc);
    end
    if (hit) begin
      check("resp", {30'h0, bus.out_resp}, {30'h0, sb[0].resp});
      check("tag",  {30'h0, bus.out_tag},  {30'h0, sb[0].tag});
      check("data", bus.out_data, sb[0].data);
      void'(sb.pop_front());
      last_out = cyc;
    end else begin
      check("idle_resp", {30'h0, bus.out_resp}, 32'h0);
      check("idle_tag",  {30'h0, bus.out_tag},  32'h0);
      check("idle_data", bus.out_data, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cmds [10];
    logic [3:0] c;
    logic [31:0] a, b;
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15, 4'd1, 4'd2};

    reset = 1'b0;
    bus.req_cmd_in  = 4'd0;
    bus.req_tag_in  = 2'd0;
    bus.req_data_in = 32'h0;
    idle(3);
    check("reset_resp", {30'h0, bus.out_resp}, 32'h0);
    check("reset_data", bus.out_data, 32'h0);

    // First command on the first edge after release
    reset = 1'b1;
    issue(4'd1, 2'd1, 32'h5, 32'h3, 4'd2);
    idle(6);

    issue(4'd1, 2'd2, 32'hFFFF_FFFF, 32'h1, 4'd0);
    issue(4'd2, 2'd3, 32'h2, 32'h3, 4'd1);
    issue(4'd2, 2'd0, 32'h7, 32'h7, 4'd5);
    issue(4'd1, 2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 4'd0);
    idle(8);

    // Long and short results completing together
    issue(4'd1, 2'd0, 32'h10, 32'h20, 4'd0);
    issue(4'd5, 2'd2, 32'h1, 32'h4, 4'd0);
    idle(8);

    issue(4'd4, 2'd3, 32'h1234, 32'h5678, 4'd0);
    issue(4'd6, 2'd1, 32'h8000_0000, 32'h1F, 4'd0);
    issue(4'd15, 2'd2, 32'hAAAA, 32'h1, 4'd0);
    issue(4'd5, 2'd0, 32'hDEAD_BEEF, 32'h0, 4'd0);
    issue(4'd5, 2'd3, 32'h0000_00F1, 32'hFFFF_FFE4, 4'd0);
    idle(8);

    // Reset right after an add's OP2 cycle, while an invalid response is on the outputs
    issue(4'd4, 2'd2, 32'h1, 32'h1, 4'd0);
    issue(4'd1, 2'd1, 32'h100, 32'h200, 4'd0);
    reset = 1'b0;
    sb.delete();
    last_out = -100;
    #1;
    check("rst_now_resp", {30'h0, bus.out_resp}, 32'h0);
    check("rst_now_tag",  {30'h0, bus.out_tag},  32'h0);
    check("rst_now_data", bus.out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(10);

    for (int i = 0; i < 64; i++) begin
      c = cmds[$urandom_range(0, 9)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a + 32'h1;
        1: b = a;
        default: b = $urandom;
      endcase
      issue(c, 2'($urandom_range(0, 3)), a, b, 4'($urandom_range(0, 15)));
    end
    idle(20);

    check("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
